updown_counter: RTL and testbench

//  Parametrised up/down counter; successor to the basic up-counter. Adds direction control, a bounded range
//  [COUNT_START..COUNT_END], wrap/saturate/one-shot modes, an enable prescaler and a terminal-count pulse.

---
 rtl/counter_pkg.sv | 25 ++
 rtl/counter_prescaler.sv | 50 +++++
 rtl/updown_counter.sv | 175 +++++++++++++++++
 tb/tb_updown_counter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the up/down counter family: counting-mode codes,
// the one-shot FSM state type and a small parameter sanity helper.
// ----------------------------------------------------------------------------
package counter_pkg;

    // Counting behaviour selected by the MODE parameter of updown_counter
    localparam int MODE_WRAP    = 0;
    localparam int MODE_SAT     = 1;
    localparam int MODE_ONESHOT = 2;

    // One-shot FSM: COUNTING while the counter is live, DONE once it has
    // stopped at a bound (only ever entered in MODE_ONESHOT)
    typedef enum logic {
        COUNTING = 1'b0,
        DONE     = 1'b1
    } cntState_e;

    // True when a MODE parameter value names one of the supported modes
    function automatic bit modeIsValid(input int mode);
        return (mode == MODE_WRAP) || (mode == MODE_SAT) || (mode == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// ----------------------------------------------------------------------------
// counter_prescaler
// Divides the count enable so the counter advances once every PRESCALE
// enabled cycles. The phase counter only moves while en is high, so gaps in
// en stretch the period without losing the phase. clr restarts the phase.
// ----------------------------------------------------------------------------
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // Phase counter width; a 1-bit register is kept even when PRESCALE is 1
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;

    // A tick is the enabled cycle that completes a full prescale period
    assign tick = en && (pcnt_q == LAST_PHASE);

    // Next phase: clear wins, otherwise step while enabled and wrap on tick
    always_comb begin
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (en) begin
            if (pcnt_q == LAST_PHASE) begin
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end
    end

    // Phase register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// ----------------------------------------------------------------------------
// updown_counter
// Bounded up/down counter over [COUNT_START..COUNT_END] with a STEP size,
// a prescaled enable and three behaviours at the bounds: wrap to the far
// bound, saturate at the reached bound, or stop there for good (one-shot).
// tc pulses for the one cycle in which dataOut shows the post-crossing value.
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module updown_counter
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_START = 0,
    parameter int COUNT_END   = 2**DATA_WIDTH - 1,
    parameter int STEP        = 1,
    parameter int PRESCALE    = 1,
    parameter int MODE        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync_clr,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] loadval,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  tc,
    output logic                  done
);

    localparam int W = DATA_WIDTH;

    // Bounds in counter width for the register paths
    localparam logic [W-1:0] START_W = W'(COUNT_START);
    localparam logic [W-1:0] END_W   = W'(COUNT_END);
    localparam logic [W-1:0] STEP_W  = W'(STEP);

    // Bounds one bit wider so the crossing tests can never overflow
    localparam logic [W:0] START_X      = (W+1)'(COUNT_START);
    localparam logic [W:0] END_X        = (W+1)'(COUNT_END);
    localparam logic [W:0] STEP_X       = (W+1)'(STEP);
    localparam logic [W:0] UP_LIMIT_X   = END_X - STEP_X;
    localparam logic [W:0] DOWN_LIMIT_X = START_X + STEP_X;

    // Reject parameter sets the counter cannot honour
    if (DATA_WIDTH < 1 || DATA_WIDTH > 31) begin : gBadWidth
        $error("updown_counter: DATA_WIDTH must be in 1..31");
    end
    if (COUNT_START < 0 || COUNT_START >= COUNT_END) begin : gBadRange
        $error("updown_counter: need 0 <= COUNT_START < COUNT_END");
    end
    if (longint'(COUNT_END) > ((longint'(1) << DATA_WIDTH) - 1)) begin : gBadEnd
        $error("updown_counter: COUNT_END does not fit in DATA_WIDTH bits");
    end
    if (STEP < 1 || STEP > (COUNT_END - COUNT_START)) begin : gBadStep
        $error("updown_counter: need 1 <= STEP <= COUNT_END-COUNT_START");
    end
    if (PRESCALE < 1) begin : gBadPrescale
        $error("updown_counter: PRESCALE must be at least 1");
    end
    if (!modeIsValid(MODE)) begin : gBadMode
        $error("updown_counter: MODE must be 0 (wrap), 1 (saturate) or 2 (one-shot)");
    end

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         tc_q;
    logic         tc_d;
    cntState_e    state_q;
    cntState_e    state_d;

    logic         tick;
    logic         canCount;
    logic [W:0]   countX;
    logic         upCross;
    logic         downCross;
    logic         crossing;
    logic [W-1:0] loadClamped;
    logic [W-1:0] wrapTarget;
    logic [W-1:0] boundTarget;

    // Prescaler restarts its phase on any clear or load
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) uPrescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync_clr | load),
        .en    (en),
        .tick  (tick)
    );

    // Crossing detection works one bit wider than the counter
    assign countX    = {1'b0, count_q};
    assign upCross   = (countX > UP_LIMIT_X);
    assign downCross = (countX < DOWN_LIMIT_X);
    assign crossing  = dir ? upCross : downCross;

    // Ticks only count while the one-shot FSM has not stopped the counter
    assign canCount  = tick && (state_q == COUNTING);

    // Bound targets for a crossing: wrap goes to the far bound, the other
    // modes stop at the bound that was reached
    assign wrapTarget  = dir ? START_W : END_W;
    assign boundTarget = dir ? END_W : START_W;

    // Clamp the load value into the legal counting range
    always_comb begin
        loadClamped = loadval;
        if ({1'b0, loadval} < START_X) begin
            loadClamped = START_W;
        end else if ({1'b0, loadval} > END_X) begin
            loadClamped = END_W;
        end
    end

    // One-shot FSM next state: clear/load re-arm, a crossing in MODE 2 stops
    always_comb begin
        state_d = state_q;
        if (sync_clr || load) begin
            state_d = COUNTING;
        end else if ((MODE == MODE_ONESHOT) && canCount && crossing) begin
            state_d = DONE;
        end
    end

    // Next count and terminal-count pulse, priority clear > load > tick
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (sync_clr) begin
            count_d = START_W;
        end else if (load) begin
            count_d = loadClamped;
        end else if (canCount) begin
            if (crossing) begin
                tc_d = 1'b1;
                if (MODE == MODE_WRAP) begin
                    count_d = wrapTarget;
                end else begin
                    count_d = boundTarget;
                end
            end else if (dir) begin
                count_d = count_q + STEP_W;
            end else begin
                count_d = count_q - STEP_W;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COUNTING;
        end else begin
            state_q <= state_d;
        end
    end

    // Count and tc registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= START_W;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign dataOut = count_q;
    assign tc      = tc_q;
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_updown_counter
// Four counters share one set of inputs: wrap, saturate and one-shot on the
// range 2..12 step 3, plus a prescale-by-3 counter on 0..15 step 1. A
// behavioural model of each is compared against the DUTs on every falling
// edge, and directed sequences pin specific values by hand.
// ----------------------------------------------------------------------------
module tb_updown_counter;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         sync_clr;
    logic         en;
    logic         dir;
    logic         load;
    logic [W-1:0] loadval;

    logic [W-1:0] dataA, dataB, dataC, dataP;
    logic         tcA, tcB, tcC, tcP;
    logic         doneA, doneB, doneC, doneP;

    int vectors     = 0;
    int miscompares = 0;
    bit checkOn     = 0;

    typedef struct {
        int count;
        int pcnt;
        bit tc;
        bit done;
    } model_t;

    model_t mA, mB, mC, mP;

    updown_counter #(.DATA_WIDTH(W), .COUNT_START(2), .COUNT_END(12), .STEP(3),
                     .PRESCALE(1), .MODE(0)) dutWrap (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .en(en), .dir(dir),
        .load(load), .loadval(loadval), .dataOut(dataA), .tc(tcA), .done(doneA));

    updown_counter #(.DATA_WIDTH(W), .COUNT_START(2), .COUNT_END(12), .STEP(3),
                     .PRESCALE(1), .MODE(1)) dutSat (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .en(en), .dir(dir),
        .load(load), .loadval(loadval), .dataOut(dataB), .tc(tcB), .done(doneB));

    updown_counter #(.DATA_WIDTH(W), .COUNT_START(2), .COUNT_END(12), .STEP(3),
                     .PRESCALE(1), .MODE(2)) dutOneShot (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .en(en), .dir(dir),
        .load(load), .loadval(loadval), .dataOut(dataC), .tc(tcC), .done(doneC));

    updown_counter #(.DATA_WIDTH(W), .COUNT_START(0), .COUNT_END(15), .STEP(1),
                     .PRESCALE(3), .MODE(0)) dutPre (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .en(en), .dir(dir),
        .load(load), .loadval(loadval), .dataOut(dataP), .tc(tcP), .done(doneP));

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state right after reset
    function automatic model_t modelInit(input int lo);
        model_t r;
        r.count = lo;
        r.pcnt  = 0;
        r.tc    = 1'b0;
        r.done  = 1'b0;
        return r;
    endfunction

    // One clock of the counter behaviour in plain integer arithmetic
    function automatic model_t modelStep(input model_t m, input int lo, input int hi,
                                         input int step, input int pre, input int mode,
                                         input bit sc, input bit ld, input int lv,
                                         input bit e, input bit d);
        model_t r;
        bit     tick;
        int     nxt;
        r    = m;
        r.tc = 1'b0;
        if (sc) begin
            r.count = lo;
            r.pcnt  = 0;
            r.done  = 1'b0;
        end else if (ld) begin
            r.count = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
            r.pcnt  = 0;
            r.done  = 1'b0;
        end else begin
            tick = e && (m.pcnt == pre - 1);
            if (e) r.pcnt = (m.pcnt + 1) % pre;
            if (tick && !m.done) begin
                nxt = d ? m.count + step : m.count - step;
                if (nxt > hi || nxt < lo) begin
                    r.tc = 1'b1;
                    if (mode == 0) r.count = d ? lo : hi;
                    else           r.count = d ? hi : lo;
                    if (mode == 2) r.done = 1'b1;
                end else begin
                    r.count = nxt;
                end
            end
        end
        return r;
    endfunction

    // Advance every model on the same edges the DUTs see
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mA <= modelInit(2);
            mB <= modelInit(2);
            mC <= modelInit(2);
            mP <= modelInit(0);
        end else begin
            mA <= modelStep(mA, 2, 12, 3, 1, 0, sync_clr, load, int'(loadval), en, dir);
            mB <= modelStep(mB, 2, 12, 3, 1, 1, sync_clr, load, int'(loadval), en, dir);
            mC <= modelStep(mC, 2, 12, 3, 1, 2, sync_clr, load, int'(loadval), en, dir);
            mP <= modelStep(mP, 0, 15, 1, 3, 0, sync_clr, load, int'(loadval), en, dir);
        end
    end

    // Single comparison with bookkeeping
    task automatic checkOutput(input string name, input logic [7:0] got, input int exp);
        vectors++;
        if (got !== 8'(exp)) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic compareDut(input string tag, input logic [W-1:0] d, input logic t,
                              input logic dn, input model_t m);
        checkOutput({tag, ".dataOut"}, {4'b0, d}, m.count);
        checkOutput({tag, ".tc"}, {7'b0, t}, int'(m.tc));
        checkOutput({tag, ".done"}, {7'b0, dn}, int'(m.done));
    endtask

    // Compare every DUT against its model on each falling edge
    always @(negedge clk) begin
        if (checkOn) begin
            compareDut("wrap", dataA, tcA, doneA, mA);
            compareDut("sat", dataB, tcB, doneB, mB);
            compareDut("oneshot", dataC, tcC, doneC, mC);
            compareDut("pre", dataP, tcP, doneP, mP);
        end
    end

    // Drive one cycle of inputs and return just after the rising edge
    task automatic applyStimulus(input bit sc, input bit ld, input int lv,
                                 input bit e, input bit d);
        @(negedge clk);
        sync_clr = sc;
        load     = ld;
        loadval  = W'(lv);
        en       = e;
        dir      = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        sync_clr = 1'b0;
        load     = 1'b0;
        en       = 1'b0;
        dir      = 1'b1;
        loadval  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        checkOn = 1'b1;
        #1;
        checkOutput("reset.wrap.data", {4'b0, dataA}, 2);
        checkOutput("reset.wrap.tc", {7'b0, tcA}, 0);
        checkOutput("reset.oneshot.done", {7'b0, doneC}, 0);
        checkOutput("reset.pre.data", {4'b0, dataP}, 0);

        // Asynchronous reset in the middle of a count
        applyStimulus(0, 1, 2, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("async.before", {4'b0, dataA}, 8);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        checkOutput("async.wrap.data", {4'b0, dataA}, 2);
        checkOutput("async.wrap.tc", {7'b0, tcA}, 0);
        checkOutput("async.oneshot.data", {4'b0, dataC}, 2);
        checkOutput("async.oneshot.done", {7'b0, doneC}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap mode, up through the top and down through the bottom
        applyStimulus(0, 1, 2, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("wrap.up1", {4'b0, dataA}, 5);
        checkOutput("wrap.up1.tc", {7'b0, tcA}, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("wrap.up2", {4'b0, dataA}, 8);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("wrap.up3", {4'b0, dataA}, 11);
        checkOutput("wrap.up3.tc", {7'b0, tcA}, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("wrap.top", {4'b0, dataA}, 2);
        checkOutput("wrap.top.tc", {7'b0, tcA}, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("wrap.after", {4'b0, dataA}, 5);
        checkOutput("wrap.after.tc", {7'b0, tcA}, 0);
        applyStimulus(0, 1, 4, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("wrap.bottom", {4'b0, dataA}, 12);
        checkOutput("wrap.bottom.tc", {7'b0, tcA}, 1);

        // Saturate mode
        applyStimulus(0, 1, 11, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("sat.top", {4'b0, dataB}, 12);
        checkOutput("sat.top.tc", {7'b0, tcB}, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("sat.hold", {4'b0, dataB}, 12);
        checkOutput("sat.hold.tc", {7'b0, tcB}, 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("sat.dn1", {4'b0, dataB}, 9);
        checkOutput("sat.dn1.tc", {7'b0, tcB}, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("sat.dn2", {4'b0, dataB}, 6);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("sat.dn3", {4'b0, dataB}, 3);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("sat.bottom", {4'b0, dataB}, 2);
        checkOutput("sat.bottom.tc", {7'b0, tcB}, 1);

        // One-shot mode
        applyStimulus(0, 1, 8, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("oneshot.up", {4'b0, dataC}, 11);
        checkOutput("oneshot.up.done", {7'b0, doneC}, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("oneshot.end", {4'b0, dataC}, 12);
        checkOutput("oneshot.end.done", {7'b0, doneC}, 1);
        checkOutput("oneshot.end.tc", {7'b0, tcC}, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, (i % 2) == 0);
            checkOutput("oneshot.halt", {4'b0, dataC}, 12);
            checkOutput("oneshot.halt.tc", {7'b0, tcC}, 0);
            checkOutput("oneshot.halt.done", {7'b0, doneC}, 1);
        end
        applyStimulus(0, 1, 4, 0, 1);
        checkOutput("oneshot.reload", {4'b0, dataC}, 4);
        checkOutput("oneshot.reload.done", {7'b0, doneC}, 0);

        // Priority and clamping
        applyStimulus(0, 1, 15, 1, 1);
        checkOutput("clamp.high", {4'b0, dataA}, 12);
        checkOutput("clamp.high.tc", {7'b0, tcA}, 0);
        applyStimulus(1, 1, 7, 1, 1);
        checkOutput("clr.over.load", {4'b0, dataA}, 2);
        applyStimulus(0, 1, 9, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("clamp.low", {4'b0, dataA}, 2);

        // Prescaler phase behaviour
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("pre.c1", {4'b0, dataP}, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("pre.c2", {4'b0, dataP}, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("pre.c3", {4'b0, dataP}, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("pre.c4", {4'b0, dataP}, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("pre.paused", {4'b0, dataP}, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("pre.resume1", {4'b0, dataP}, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("pre.resume2", {4'b0, dataP}, 2);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 1, 5, 1, 1);
        checkOutput("pre.load", {4'b0, dataP}, 5);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("pre.phase1", {4'b0, dataP}, 5);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("pre.phase2", {4'b0, dataP}, 5);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("pre.phase3", {4'b0, dataP}, 6);

        applyStimulus(0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
